// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor controller: one full-subtractor cell, LSB first, start/busy/done.
// Optional SERIAL_SUB_SAT_EN: saturate Y to 0 on a final borrow.
module serial_sub_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y,
    output logic             borrow
);

    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, y_q, y_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             br_q, br_d, borrow_q, borrow_d, done_q, done_d;
    logic             bit_a, bit_b, diff, bo;

    // Subtract cell
    assign bit_a = a_q[0];
    assign bit_b = b_q[0];
    assign diff  = bit_a ^ bit_b ^ br_q;
    assign bo    = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        borrow_d = borrow_q;
        done_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                res_d = {diff, res_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = bo;
                if (cnt_q == CntLast) begin
`ifdef SERIAL_SUB_SAT_EN
                    y_d = bo ? '0 : res_d;
`else
                    y_d = res_d;
`endif
                    borrow_d = bo;
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            y_q      <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            y_q      <= y_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == StRun);
    assign done   = done_q;
    assign Y      = y_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: cycle-level reference model plus directed literal checks.
module tb_serial_sub_ctrl;

    localparam int unsigned W = 8;
`ifdef SERIAL_SUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] A = '0, B = '0;
    logic         busy, done, borrow;
    logic [W-1:0] Y;

    logic         start4 = 1'b0;
    logic [3:0]   a4 = '0, b4 = '0;
    logic         busy4, done4, borrow4;
    logic [3:0]   y4;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .Y(Y), .borrow(borrow)
    );

    serial_sub_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4),
        .busy(busy4), .done(done4), .Y(y4), .borrow(borrow4)
    );

    // Reference model: an accepted request yields (A-B) mod 2^W exactly W cycles later.
    logic         m_busy = 1'b0, m_done = 1'b0, m_borrow = 1'b0, p_b = 1'b0;
    logic [W-1:0] m_y = '0, p_y = '0;
    int           m_rem = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_y      <= '0;
            m_borrow <= 1'b0;
            m_rem    <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_rem == 1) begin
                    m_busy   <= 1'b0;
                    m_done   <= 1'b1;
                    m_y      <= p_y;
                    m_borrow <= p_b;
                end
                m_rem <= m_rem - 1;
            end else if (start) begin
                m_busy <= 1'b1;
                m_rem  <= W;
                p_b    <= (A < B);
                p_y    <= (SAT && (A < B)) ? '0 : A - B;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("model busy", {31'd0, busy}, {31'd0, m_busy});
            check("model done", {31'd0, done}, {31'd0, m_done});
            check("model Y", {24'd0, Y}, {24'd0, m_y});
            check("model borrow", {31'd0, borrow}, {31'd0, m_borrow});
            if (busy && done) check("busy&done exclusive", 32'd1, 32'd0);
        end
    end

    // Called just after a negedge; start is sampled at the next posedge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        #1;
        A = a;
        B = b;
        start = 1'b1;
        @(negedge clk);
    endtask

    // Returns positioned at the negedge where done is seen.
    task automatic wait_done(output int bc, output bit got);
        bc  = 0;
        got = 1'b0;
        for (int k = 0; k < 4 * W; k++) begin
            if (k > 0) @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) bc++;
            if (k == 0) begin
                #1;
                start = 1'b0;
                A = W'($urandom);
                B = W'($urandom);
            end
        end
        check("done within bound", {31'd0, got}, 32'd1);
    endtask

    int  bc, t_prev;
    bit  got;
    int  ndone;
    logic [W-1:0] edge_a [4] = '{8'd0, 8'd255, 8'd0, 8'd255};
    logic [W-1:0] edge_b [4] = '{8'd0, 8'd255, 8'd1, 8'd0};
    logic [W-1:0] edge_y [4];
    logic         edge_br[4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        edge_y[0] = 8'd0;
        edge_y[1] = 8'd0;
        edge_y[2] = SAT ? 8'd0 : 8'd255;
        edge_y[3] = 8'd255;

        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset Y", {24'd0, Y}, 32'd0);
        check("reset borrow", {31'd0, borrow}, 32'd0);
        #1 rst_n = 1'b1;
        chk_on = 1'b1;
        @(negedge clk);

        // Basic subtract
        launch(8'd200, 8'd55);
        wait_done(bc, got);
        check("basic Y", {24'd0, Y}, 32'd145);
        check("basic model Y", {24'd0, m_y}, 32'd145);
        check("basic borrow", {31'd0, borrow}, 32'd0);
        check("basic busy cycles", bc, W);
        @(negedge clk);
        check("done one cycle", {31'd0, done}, 32'd0);
        check("Y holds", {24'd0, Y}, 32'd145);

        // Underflow
        launch(8'd5, 8'd9);
        wait_done(bc, got);
        check("underflow Y", {24'd0, Y}, SAT ? 32'd0 : 32'd252);
        check("underflow borrow", {31'd0, borrow}, 32'd1);
        @(negedge clk);

        // Edge operands back-to-back, start raised inside each done cycle
        t_prev = 0;
        for (int i = 0; i < 4; i++) begin
            launch(edge_a[i], edge_b[i]);
            wait_done(bc, got);
            check("edge Y", {24'd0, Y}, {24'd0, edge_y[i]});
            check("edge borrow", {31'd0, borrow}, {31'd0, edge_br[i]});
            if (i > 0) check("edge spacing", cyc - t_prev, 32'd9);
            t_prev = cyc;
        end
        @(negedge clk);

        // Start while busy is ignored
        launch(8'd100, 8'd30);
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            if (done) ndone++;
            if (done) check("busy-start Y", {24'd0, Y}, 32'd70);
            if (done) check("busy-start borrow", {31'd0, borrow}, 32'd0);
            if (k == 0) begin #1; start = 1'b0; end
            if (k == 2) begin #1; start = 1'b1; A = 8'd1; B = 8'd2; end
            if (k == 3) begin #1; start = 1'b0; end
        end
        check("busy-start single done", ndone, 32'd1);

        // Reset mid-operation
        launch(8'd50, 8'd20);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid-reset busy", {31'd0, busy}, 32'd0);
        check("mid-reset done", {31'd0, done}, 32'd0);
        check("mid-reset Y", {24'd0, Y}, 32'd0);
        check("mid-reset borrow", {31'd0, borrow}, 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("no done after reset", ndone, 32'd0);
        launch(8'd9, 8'd4);
        wait_done(bc, got);
        check("post-reset Y", {24'd0, Y}, 32'd5);

        // Randomized traffic, model-checked every cycle
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            launch(W'($urandom), W'($urandom));
            wait_done(bc, got);
        end
        @(negedge clk);

        // WIDTH=4 instance
        #1;
        a4 = 4'd3;
        b4 = 4'd7;
        start4 = 1'b1;
        @(negedge clk);
        #1 start4 = 1'b0;
        bc  = 1;
        got = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (done4) begin
                got = 1'b1;
                break;
            end
            if (busy4) bc++;
        end
        check("w4 done seen", {31'd0, got}, 32'd1);
        check("w4 busy cycles", bc, 32'd4);
        check("w4 Y", {28'd0, y4}, SAT ? 32'd0 : 32'd12);
        check("w4 borrow", {31'd0, borrow4}, 32'd1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
